// File: rtl/i2c_pkg.sv
// Shared definitions for the AXI-stream I2C command arbiter.
// Holds the arbiter state encoding and the default error word that is
// returned when a read is abandoned by the watchdog.
package i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } arb_state_t;

    localparam logic [31:0] I2C_ERROR_VALUE = 32'hdeadbeef;

    // Width of an index into a vector of n entries, never narrower than 1 bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_i2c_arbiter_rr.sv
// Round-robin requester selection for axis_i2c_arbiter.
// The search starts at the entry after last_grant and wraps, so the most
// recent owner is considered last. A single-entry instance is a wire.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [W-1:0] grant,
    output logic         any
);

    generate
        if (N == 1) begin : g_single
            logic unused_last;
            assign unused_last = ^last_grant;
            assign grant       = '0;
            assign any         = req[0];
        end else begin : g_rr
            // Walk from farthest to nearest so the nearest active request is the last write.
            always_comb begin
                int idx;
                grant = last_grant;
                any   = 1'b0;
                idx   = 0;
                for (int i = N; i >= 1; i--) begin
                    idx = int'(last_grant) + i;
                    if (idx >= N) begin
                        idx = idx - N;
                    end
                    if (req[idx]) begin
                        grant = W'(idx);
                        any   = 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/axis_i2c_arbiter.sv
// Arbitrates several AXI-stream style command requesters onto one I2C master.
// One transaction is outstanding at a time: grant, issue the command, optionally
// wait for the read response, then deliver it back to the owner.
// Optional build macro I2C_ARB_TIMEOUT_EN adds a response watchdog that returns
// ERROR_VALUE when the master never answers.
module axis_i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int          REQ_COUNT     = 4,
    parameter int          BUS_BITS      = 1,
    parameter int          DATA_WR_BITS  = 2,
    parameter int          DATA_RD_BITS  = 2,
    parameter int          DATA_WR_COUNT = 4,
    parameter int          DATA_RD_COUNT = 4,
    parameter int          NOTIFY_ALL    = 0,
    parameter int          TIMEOUT_BITS  = 20,
    parameter logic [31:0] ERROR_VALUE   = I2C_ERROR_VALUE
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [REQ_COUNT*BUS_BITS-1:0]             s_busno,
    input  logic [REQ_COUNT*(DATA_WR_BITS+1)-1:0]     s_wrlen,
    input  logic [REQ_COUNT*(DATA_RD_BITS+1)-1:0]     s_rdlen,
    input  logic [REQ_COUNT*7-1:0]                    s_addr,
    input  logic [REQ_COUNT*DATA_WR_COUNT*8-1:0]      s_data,
    input  logic [REQ_COUNT-1:0]                      s_valid,
    output logic [REQ_COUNT-1:0]                      s_ready,
    output logic [DATA_RD_COUNT*8-1:0]                m_rx_data,
    output logic [REQ_COUNT-1:0]                      m_rx_valid,
    input  logic [REQ_COUNT-1:0]                      m_rx_ready,
    output logic [BUS_BITS-1:0]                       c_busno,
    output logic [DATA_WR_BITS:0]                     c_wrlen,
    output logic [DATA_RD_BITS:0]                     c_rdlen,
    output logic [6:0]                                c_addr,
    output logic [DATA_WR_COUNT*8-1:0]                c_data,
    output logic                                      c_valid,
    input  logic                                      c_ready,
    input  logic [DATA_RD_COUNT*8-1:0]                r_data,
    input  logic                                      r_valid,
    output logic                                      r_ready,
    output logic                                      busy,
    output logic [idx_bits(REQ_COUNT)-1:0]            grant_id
);

    localparam int GW = idx_bits(REQ_COUNT);
    localparam int WL = DATA_WR_BITS + 1;
    localparam int RL = DATA_RD_BITS + 1;
    localparam int WD = DATA_WR_COUNT * 8;
    localparam int RD = DATA_RD_COUNT * 8;

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] win;
    logic          any_req;
    logic          need_rsp;
    logic          cmd_hs;
    logic          rsp_take;
    logic          dlv_hs;
    logic          wd_expired;
    logic          grant_now;

    rr_arbiter #(
        .N (REQ_COUNT),
        .W (GW)
    ) u_rr (
        .req        (s_valid),
        .last_grant (last_grant),
        .grant      (win),
        .any        (any_req)
    );

    assign grant_now = (state == ST_IDLE) && any_req;
    assign need_rsp  = (c_rdlen != '0) || (NOTIFY_ALL != 0);
    assign cmd_hs    = (state == ST_ISSUE) && c_ready;
    assign rsp_take  = (state == ST_WAIT) && r_valid;
    assign dlv_hs    = (state == ST_DELIVER) && m_rx_ready[grant_id];

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [RD-1:0] ERR_FILL = RD'(ERROR_VALUE);
    logic [TIMEOUT_BITS-1:0]  watchdog;

    assign wd_expired = (state == ST_WAIT) && !r_valid && (&watchdog);

    // Watchdog counts response-wait cycles and is cleared in every other state.
    always_ff @(posedge clk) begin
        if (rst) begin
            watchdog <= '0;
        end else if (state == ST_WAIT) begin
            watchdog <= watchdog + 1'b1;
        end else begin
            watchdog <= '0;
        end
    end
`else
    logic [31:0] unused_cfg;
    assign unused_cfg = ERROR_VALUE ^ 32'(TIMEOUT_BITS);
    assign wd_expired = 1'b0;
`endif

    // Control state: FSM state, current owner and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= GW'(REQ_COUNT - 1);
            grant_id   <= '0;
        end else begin
            state <= state_nxt;
            if (grant_now) begin
                grant_id <= win;
            end
            // The pointer advances only once the owner's transaction is fully done.
            if ((cmd_hs && !need_rsp) || dlv_hs) begin
                last_grant <= grant_id;
            end
        end
    end

    // Next-state decision for the single-outstanding transaction sequence.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (any_req) state_nxt = ST_ISSUE;
            ST_ISSUE:   if (c_ready) state_nxt = need_rsp ? ST_WAIT : ST_IDLE;
            ST_WAIT:    if (r_valid || wd_expired) state_nxt = ST_DELIVER;
            ST_DELIVER: if (m_rx_ready[grant_id]) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state; only the owner's bits ever rise.
    always_comb begin
        s_ready    = '0;
        m_rx_valid = '0;
        c_valid    = (state == ST_ISSUE);
        r_ready    = (state == ST_WAIT);
        busy       = (state != ST_IDLE);
        if (cmd_hs) begin
            s_ready[grant_id] = 1'b1;
        end
        if (state == ST_DELIVER) begin
            m_rx_valid[grant_id] = 1'b1;
        end
    end

    // Datapath capture: command snapshot at grant, response word in the wait state.
    always_ff @(posedge clk) begin
        if (grant_now) begin
            c_busno <= s_busno[win*BUS_BITS +: BUS_BITS];
            c_wrlen <= s_wrlen[win*WL +: WL];
            c_rdlen <= s_rdlen[win*RL +: RL];
            c_addr  <= s_addr[win*7 +: 7];
            c_data  <= s_data[win*WD +: WD];
        end
        if (rsp_take) begin
            m_rx_data <= r_data;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (wd_expired) begin
            m_rx_data <= ERR_FILL;
        end
`endif
    end

endmodule

// File: tb/tb_axis_i2c_arbiter.sv
// Scoreboard bench for axis_i2c_arbiter: a transaction-level model predicts
// grants and responses into queues; a monitor pops and compares them.
module tb_axis_i2c_arbiter;

    localparam int N  = 4;
    localparam int BB = 1;
    localparam int WB = 2;
    localparam int RB = 2;
    localparam int WC = 4;
    localparam int RC = 4;
    localparam int TB = 4;
    localparam int WL = WB + 1;
    localparam int RL = RB + 1;
    localparam int WD = WC * 8;
    localparam int RD = RC * 8;
    localparam logic [RD-1:0] ERRV = 32'hdeadbeef;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N*BB-1:0]   s_busno = '0;
    logic [N*WL-1:0]   s_wrlen = '0;
    logic [N*RL-1:0]   s_rdlen = '0;
    logic [N*7-1:0]    s_addr = '0;
    logic [N*WD-1:0]   s_data = '0;
    logic [N-1:0]      s_valid = '0;
    logic [N-1:0]      s_ready;
    logic [RD-1:0]     m_rx_data;
    logic [N-1:0]      m_rx_valid;
    logic [N-1:0]      m_rx_ready = '0;
    logic [BB-1:0]     c_busno;
    logic [WL-1:0]     c_wrlen;
    logic [RL-1:0]     c_rdlen;
    logic [6:0]        c_addr;
    logic [WD-1:0]     c_data;
    logic              c_valid;
    logic              c_ready = 1'b0;
    logic [RD-1:0]     r_data = '0;
    logic              r_valid = 1'b0;
    logic              r_ready;
    logic              busy;
    logic [1:0]        grant_id;

    axis_i2c_arbiter #(
        .REQ_COUNT(N), .BUS_BITS(BB), .DATA_WR_BITS(WB), .DATA_RD_BITS(RB),
        .DATA_WR_COUNT(WC), .DATA_RD_COUNT(RC), .NOTIFY_ALL(0), .TIMEOUT_BITS(TB)
    ) dut (
        .clk(clk), .rst(rst),
        .s_busno(s_busno), .s_wrlen(s_wrlen), .s_rdlen(s_rdlen), .s_addr(s_addr),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_rx_data(m_rx_data), .m_rx_valid(m_rx_valid), .m_rx_ready(m_rx_ready),
        .c_busno(c_busno), .c_wrlen(c_wrlen), .c_rdlen(c_rdlen), .c_addr(c_addr),
        .c_data(c_data), .c_valid(c_valid), .c_ready(c_ready),
        .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BB-1:0] busno;
        logic [WL-1:0] wrlen;
        logic [RL-1:0] rdlen;
        logic [6:0]    addr;
        logic [WD-1:0] data;
        int            id;
    } cmd_t;

    cmd_t          exp_cmd[$];
    logic [RD-1:0] exp_rsp[$];
    int            glog[$];
    int            checks = 0;
    int            errors = 0;
    int            seen_err = 0;

    // Model: phase 0 free, 1 command offered, 2 awaiting response, 3 delivering.
    int   ph = 0;
    int   m_last = N - 1;
    int   m_owner = 0;
    int   m_wd = 0;
    cmd_t m_cur;
    bit   pend[N];
    bit   granted[N];
    cmd_t rq[N];

    int p_new = 0, p_cr = 100, p_rv = 0, p_mr = 100;
    bit rd_en = 1'b0, force_rd = 1'b0, all_on = 1'b0, drop_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic cmd_t rand_cmd(input int id);
        cmd_t c;
        c.busno = BB'($urandom);
        c.wrlen = WL'($urandom);
        if (force_rd)   c.rdlen = RL'($urandom_range(1, (1 << RL) - 1));
        else if (rd_en) c.rdlen = RL'($urandom_range(0, (1 << RL) - 1));
        else            c.rdlen = '0;
        c.addr = 7'($urandom);
        c.data = WD'($urandom);
        c.id   = id;
        return c;
    endfunction

    task automatic model_reset();
        ph = 0; m_last = N - 1; m_wd = 0;
        exp_cmd.delete(); exp_rsp.delete(); glog.delete();
        for (int i = 0; i < N; i++) begin pend[i] = 0; granted[i] = 0; end
    endtask

    // Advances the model over the coming rising edge using the driven inputs.
    task automatic model_step();
        int w; bit found;
        case (ph)
            0: begin
                found = 0; w = 0;
                for (int k = 1; k <= N; k++) begin
                    if (!found && pend[(m_last + k) % N]) begin found = 1; w = (m_last + k) % N; end
                end
                if (found) begin
                    m_owner = w; m_cur = rq[w]; m_cur.id = w;
                    exp_cmd.push_back(m_cur);
                    granted[w] = 1; ph = 1;
                    rq[w].addr = 7'($urandom); rq[w].data = WD'($urandom);
                end
            end
            1: if (c_ready) begin
                pend[m_owner] = 0; granted[m_owner] = 0;
                if (m_cur.rdlen != 0) begin ph = 2; m_wd = 0; end
                else begin ph = 0; m_last = m_owner; end
            end
            2: begin
                if (r_valid) begin exp_rsp.push_back(r_data); ph = 3; end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (m_wd == (1 << TB) - 1) begin exp_rsp.push_back(ERRV); ph = 3; end
                else m_wd++;
`endif
            end
            default: if (m_rx_ready[m_owner]) begin ph = 0; m_last = m_owner; end
        endcase
    endtask

    task automatic cycle(input bit r);
        @(negedge clk);
        rst = r;
        for (int i = 0; i < N; i++) begin
            if (r) begin
                pend[i] = 0; granted[i] = 0;
            end else if (!pend[i]) begin
                if (all_on || ($urandom_range(99) < p_new)) begin pend[i] = 1; rq[i] = rand_cmd(i); end
            end else if (!granted[i] && drop_en && ($urandom_range(99) < 5)) begin
                pend[i] = 0;
            end
        end
        c_ready = ($urandom_range(99) < p_cr);
        r_valid = ($urandom_range(99) < p_rv);
        r_data  = RD'($urandom);
        for (int i = 0; i < N; i++) m_rx_ready[i] = ($urandom_range(99) < p_mr);
        for (int i = 0; i < N; i++) begin
            s_valid[i]          = pend[i];
            s_busno[i*BB +: BB] = rq[i].busno;
            s_wrlen[i*WL +: WL] = rq[i].wrlen;
            s_rdlen[i*RL +: RL] = rq[i].rdlen;
            s_addr[i*7 +: 7]    = rq[i].addr;
            s_data[i*WD +: WD]  = rq[i].data;
        end
        #2;
        if (r) model_reset();
        else   model_step();
    endtask

    task automatic drain();
        int n; bit left;
        p_new = 0; all_on = 0; drop_en = 0; p_cr = 100; p_rv = 100; p_mr = 100;
        n = 0;
        do begin
            cycle(1'b0);
            n++;
            left = (ph != 0);
            for (int i = 0; i < N; i++) if (pend[i]) left = 1;
        end while (left && n < 200);
        chk("drain_done", left, 1'b0);
        chk("cmd_queue_empty", exp_cmd.size(), 0);
        chk("rsp_queue_empty", exp_rsp.size(), 0);
    endtask

    // Monitor: compares DUT outputs against the model phase and the expectation queues.
    initial begin
        logic [N-1:0] oh;
        cmd_t e;
        forever begin
            @(negedge clk);
            #1;
            chk("c_valid", c_valid, ph == 1);
            chk("busy", busy, ph != 0);
            chk("r_ready", r_ready, ph == 2);
            if (c_valid && c_ready) begin
                if (exp_cmd.size() == 0) begin
                    chk("cmd_unexpected", 1'b1, 1'b0);
                end else begin
                    e = exp_cmd.pop_front();
                    oh = '0; oh[e.id] = 1'b1;
                    chk("grant_id", grant_id, e.id);
                    chk("s_ready_pulse", s_ready, oh);
                    chk("c_addr", c_addr, e.addr);
                    chk("c_data", c_data, e.data);
                    chk("c_busno", c_busno, e.busno);
                    chk("c_wrlen", c_wrlen, e.wrlen);
                    chk("c_rdlen", c_rdlen, e.rdlen);
                    glog.push_back(int'(grant_id));
                end
            end else begin
                chk("s_ready_quiet", s_ready, '0);
            end
            oh = '0;
            if (ph == 3) oh[m_owner] = 1'b1;
            chk("m_rx_valid", m_rx_valid, oh);
            if (m_rx_valid != '0) begin
                if (exp_rsp.size() == 0) begin
                    chk("rsp_unexpected", 1'b1, 1'b0);
                end else begin
                    chk("m_rx_data", m_rx_data, exp_rsp[0]);
                    if ((m_rx_valid & m_rx_ready) != '0) begin
                        if (exp_rsp[0] == ERRV) seen_err++;
                        void'(exp_rsp.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int n;
        model_reset();
        cycle(1'b1);
        cycle(1'b1);
        chk("grant_id_reset", grant_id, 0);

        // Mixed random traffic with drops, reads, stalls and stray responses.
        p_new = 30; p_cr = 60; p_rv = 40; p_mr = 50; rd_en = 1; drop_en = 1;
        repeat (1500) cycle(1'b0);
        drain();

        // Everyone requesting back-to-back writes: strict rotation from 0.
        cycle(1'b1);
        cycle(1'b1);
        all_on = 1; rd_en = 0; drop_en = 0; p_cr = 100; p_rv = 30; p_mr = 100;
        repeat (12) cycle(1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i < glog.size()) chk("rr_order", glog[i], i % N);
            else                 chk("rr_order_missing", 1'b1, 1'b0);
        end
        drain();

        // Reset while waiting for a read response; a late response must be ignored.
        force_rd = 1; p_new = 100; p_cr = 100; p_rv = 0; p_mr = 100;
        n = 0;
        while (ph != 2 && n < 50) begin cycle(1'b0); n++; end
        chk("reached_wait", ph, 2);
        cycle(1'b1);
        cycle(1'b1);
        chk("rst_wait_c_valid", c_valid, 1'b0);
        chk("rst_wait_m_rx_valid", m_rx_valid, '0);
        p_new = 0; p_rv = 100;
        repeat (8) cycle(1'b0);
        chk("late_r_ready", r_ready, 1'b0);
        force_rd = 0;

`ifdef I2C_ARB_TIMEOUT_EN
        // Silent master: every read ends in the error word after 16 wait cycles.
        force_rd = 1; p_new = 100; p_rv = 0; p_mr = 100; p_cr = 100;
        repeat (80) cycle(1'b0);
        force_rd = 0;
        drain();
        chk("timeout_seen", seen_err > 0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
